// File: rtl/serial_comparator_ctrl.sv
// Sequenced unsigned magnitude comparator: latches A/B on a start handshake,
// then compares one bit per clock MSB-first and presents one-hot
// greater/equal/lesser flags behind a valid/ready result handshake.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   start_valid/ready - command handshake; ready is high only while idle
//   A, B              - operands, sampled on the start handshake
//   result_valid/ready- result handshake; flags hold while stalled
//   A_greater_B, A_equal_B, A_lesser_B - one-hot result flags
//   busy              - high while scanning or holding a result
//   bits_examined     - bit positions compared for the current/last result
module serial_comparator_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1,
    parameter int unsigned CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_lesser_B,
    output logic             busy,
    output logic [CNT_W-1:0] bits_examined
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic             gt_s_q, gt_s_d;
    logic             lt_s_q, lt_s_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             rv_q, rv_d;
    logic             busy_q, busy_d;

    logic             a_bit_c;
    logic             b_bit_c;
    logic             gt_new_c;
    logic             lt_new_c;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        gt_s_d  = gt_s_q;
        lt_s_d  = lt_s_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        rv_d    = rv_q;
        busy_d  = busy_q;

        a_bit_c = a_q[idx_q];
        b_bit_c = b_q[idx_q];
        // Sticky flags only latch on the first (most significant) difference
        gt_new_c = gt_s_q | (~lt_s_q &  a_bit_c & ~b_bit_c);
        lt_new_c = lt_s_q | (~gt_s_q & ~a_bit_c &  b_bit_c);

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IDX_W'(WIDTH - 1);
                    bits_d  = '0;
                    gt_s_d  = 1'b0;
                    lt_s_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                bits_d = bits_q + CNT_W'(1);
                if (EARLY_EXIT) begin
                    if (a_bit_c != b_bit_c) begin
                        gt_d    = a_bit_c;
                        lt_d    = b_bit_c;
                        rv_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (idx_q == '0) begin
                        eq_d    = 1'b1;
                        rv_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    gt_s_d = gt_new_c;
                    lt_s_d = lt_new_c;
                    if (idx_q == '0) begin
                        gt_d    = gt_new_c;
                        lt_d    = lt_new_c;
                        eq_d    = ~(gt_new_c | lt_new_c);
                        rv_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            S_DONE: begin
                // bits_examined deliberately keeps the last count
                if (result_ready) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    rv_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_W'(WIDTH - 1);
            bits_q  <= '0;
            gt_s_q  <= 1'b0;
            lt_s_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            gt_s_q  <= gt_s_d;
            lt_s_q  <= lt_s_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
        end
    end

    assign start_ready   = (state_q == S_IDLE);
    assign result_valid  = rv_q;
    assign A_greater_B   = gt_q;
    assign A_equal_B     = eq_q;
    assign A_lesser_B    = lt_q;
    assign busy          = busy_q;
    assign bits_examined = bits_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Bench for serial_comparator_ctrl: one early-exit and one fixed-latency
// instance share the stimulus and are checked against an arithmetic model.
module tb_serial_comparator_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  start_valid;
    logic                  result_ready;
    logic [W-1:0]          a;
    logic [W-1:0]          b;
    logic [1:0]            sr;
    logic [1:0]            rv;
    logic [1:0]            gt;
    logic [1:0]            eq;
    logic [1:0]            lt;
    logic [1:0]            bsy;
    logic [1:0][CW-1:0]    bits;

    int n_assert;
    int n_fail;

    serial_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(sr[0]),
        .A(a), .B(b),
        .result_valid(rv[0]), .result_ready(result_ready),
        .A_greater_B(gt[0]), .A_equal_B(eq[0]), .A_lesser_B(lt[0]),
        .busy(bsy[0]), .bits_examined(bits[0])
    );

    serial_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fl (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(sr[1]),
        .A(a), .B(b),
        .result_valid(rv[1]), .result_ready(result_ready),
        .A_greater_B(gt[1]), .A_equal_B(eq[1]), .A_lesser_B(lt[1]),
        .busy(bsy[1]), .bits_examined(bits[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge count until the result for the given mode, from the spec's rule
    function automatic int model_latency(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
        logic [W-1:0] d;
        int hi;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < int'(W); i++) if (d[i]) hi = i;
        if (!early || hi < 0) return int'(W);
        return int'(W) - hi;
    endfunction

    // One compare through both instances; rnd_rr adds random result stalls
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit rnd_rr, input string tag);
        logic exp_g, exp_e, exp_l;
        int   lat [2];
        bit   seen [2];
        bit   gone [2];
        int   cyc;
        exp_g = (x > y);
        exp_e = (x == y);
        exp_l = (x < y);
        lat[0] = model_latency(x, y, 1'b1);
        lat[1] = model_latency(x, y, 1'b0);
        seen[0] = 1'b0; seen[1] = 1'b0;
        gone[0] = 1'b0; gone[1] = 1'b0;

        a = x;
        b = y;
        start_valid  = 1'b1;
        result_ready = rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cyc = 0;
        while (!(gone[0] && gone[1]) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!seen[k]) begin
                    if (rv[k] === 1'b1) begin
                        seen[k] = 1'b1;
                        check({tag, "_lat"},  32'(cyc),     32'(lat[k]));
                        check({tag, "_gt"},   32'(gt[k]),   32'(exp_g));
                        check({tag, "_eq"},   32'(eq[k]),   32'(exp_e));
                        check({tag, "_lt"},   32'(lt[k]),   32'(exp_l));
                        check({tag, "_bits"}, 32'(bits[k]), 32'(lat[k]));
                    end else begin
                        check({tag, "_scan_busy"}, 32'({bsy[k], sr[k], gt[k], eq[k], lt[k]}), 32'(5'b10000));
                    end
                end else if (!gone[k]) begin
                    if (rv[k] === 1'b0) begin
                        gone[k] = 1'b1;
                        check({tag, "_after"}, 32'({sr[k], bsy[k], gt[k], eq[k], lt[k]}), 32'(5'b10000));
                        check({tag, "_bits_hold"}, 32'(bits[k]), 32'(lat[k]));
                    end else begin
                        check({tag, "_hold"}, 32'({sr[k], gt[k], eq[k], lt[k]}), 32'({1'b0, exp_g, exp_e, exp_l}));
                    end
                end
            end
            result_ready = rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (cyc >= 300) check({tag, "_timeout"}, 32'(cyc), 32'(0));
        result_ready = 1'b1;
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        a            = '0;
        b            = '0;
        #12;
        check("reset_outputs", 32'({rv, gt, eq, lt, bsy, bits}), 32'(0));
        check("reset_ready",   32'(sr), 32'(2'b11));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed patterns
        run_op(8'h80, 8'h7F, 1'b0, "msb_diff");
        run_op(8'hA5, 8'hA1, 1'b0, "bit2_gt");
        run_op(8'hA1, 8'hA5, 1'b0, "bit2_lt");
        run_op(8'h3C, 8'h3C, 1'b0, "equal");
        run_op(8'h12, 8'h13, 1'b0, "lsb_lt");
        run_op(8'h00, 8'h00, 1'b0, "zero_eq");
        run_op(8'hFF, 8'hFF, 1'b0, "ones_eq");

        // Backpressure: result held while new starts are offered and ignored
        a = 8'h01;
        b = 8'h00;
        start_valid  = 1'b1;
        result_ready = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_valid", 32'(rv), 32'(2'b11));
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check("bp_flags", 32'({gt, eq, lt}), 32'(6'b11_00_00));
            check("bp_ready", 32'({sr, rv}), 32'(4'b00_11));
            check("bp_bits",  32'(bits), 32'({4'd8, 4'd8}));
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({rv, sr, gt, eq, lt}), 32'(10'b00_11_00_00_00));

        // Asynchronous reset in the third scan cycle
        a = 8'h00;
        b = 8'h01;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_reset_busy", 32'(bsy), 32'(2'b11));
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({rv, gt, eq, lt, bsy, bits}), 32'(0));
        check("async_ready", 32'(sr), 32'(2'b11));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'hFF, 8'hFE, 1'b0, "post_reset");

        // Random operand pairs with random result stalls
        for (int n = 0; n < 1000; n++) begin
            x = W'($urandom);
            case ($urandom_range(0, 7))
                0:       y = x;
                1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            run_op(x, y, 1'b1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
